// File: rtl/dmem_wb_arbiter.sv
// Two-master Wishbone arbiter/sequencer for the single-ported data memory.
// Each transfer runs IDLE -> ISSUE -> RESP so the slave's registered read data lines up with the master ack.
module dmem_wb_arbiter #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        reset_n,
  // master 0: core load/store port
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1: DMA/debug port
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // data memory slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_gnt;
  logic        r_prio;
  logic        r_err_pending;
  logic        r_we;
  logic [31:0] r_adr;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic        r_proto_fault;

  logic        w_req0;
  logic        w_req1;
  logic        w_any_req;
  logic        w_win;
  logic        w_win_we;
  logic [31:0] w_win_adr;
  logic [3:0]  w_win_sel;
  logic [31:0] w_win_dat;
  logic        w_oor;
  logic        w_idle;
  logic        w_issue;
  logic        w_resp;
  logic        w_gnt_cyc;
  logic        w_ack;
  logic        w_err;
  logic [31:0] w_rdat;
  logic        w_unused;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_any_req = w_req0 | w_req1;

  // A lone requester always wins; on contention the round-robin pointer decides.
  assign w_win     = (w_req0 & w_req1) ? r_prio : w_req1;
  assign w_win_we  = w_win ? m1_we_i  : m0_we_i;
  assign w_win_adr = w_win ? m1_adr_i : m0_adr_i;
  assign w_win_sel = w_win ? m1_sel_i : m0_sel_i;
  assign w_win_dat = w_win ? m1_dat_i : m0_dat_i;
  assign w_oor     = ({6'd0, w_win_adr[27:2]} >= DEPTH);

  assign w_idle  = (r_state == ST_IDLE);
  assign w_issue = (r_state == ST_ISSUE);
  assign w_resp  = (r_state == ST_RESP);

  // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = w_oor ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_gnt         <= 1'b0;
      r_prio        <= 1'b0;
      r_err_pending <= 1'b0;
      r_we          <= 1'b0;
      r_adr         <= '0;
      r_sel         <= '0;
      r_dat         <= '0;
      r_proto_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && w_any_req) begin
        r_gnt         <= w_win;
        r_we          <= w_win_we;
        r_adr         <= w_win_adr;
        r_sel         <= w_win_sel;
        r_dat         <= w_win_dat;
        r_err_pending <= w_oor;
      end
      // Fairness advances on every finished transfer, even one whose master walked away.
      if (w_resp) r_prio <= ~r_gnt;
      if (w_issue && !s_ack_i) r_proto_fault <= 1'b1;
    end
  end

  // The protocol-fault flag is kept for debug visibility only.
  assign w_unused = r_proto_fault;

  assign s_cyc_o = w_issue;
  assign s_stb_o = w_issue;
  assign s_we_o  = w_issue & r_we;
  assign s_adr_o = w_issue ? r_adr : '0;
  assign s_sel_o = w_issue ? r_sel : '0;
  assign s_dat_o = w_issue ? r_dat : '0;

  // A master that dropped cyc mid-transfer gets no termination.
  assign w_gnt_cyc = r_gnt ? m1_cyc_i : m0_cyc_i;
  assign w_ack     = w_resp & ~r_err_pending & w_gnt_cyc;
  assign w_err     = w_resp &  r_err_pending & w_gnt_cyc;
  assign w_rdat    = (w_ack & ~r_we) ? s_dat_i : '0;

  assign m0_ack_o = w_ack & ~r_gnt;
  assign m0_err_o = w_err & ~r_gnt;
  assign m0_dat_o = r_gnt ? '0 : w_rdat;
  assign m1_ack_o = w_ack & r_gnt;
  assign m1_err_o = w_err & r_gnt;
  assign m1_dat_o = r_gnt ? w_rdat : '0;

endmodule

// File: tb/tb_dmem_wb_arbiter.sv
// Scoreboard bench for dmem_wb_arbiter: a transfer-level model predicts grant order, slave accesses and
// master responses; monitors compare whatever the DUT presents against the queued expectations.
module tb_dmem_wb_arbiter;

  localparam int unsigned DEPTH = 1024;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  typedef struct packed {
    logic        is_err;
    logic [31:0] dat;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } slv_t;

  logic clk_i   = 1'b0;
  logic reset_n = 1'b1;

  logic [1:0]       m_cyc = '0, m_stb = '0, m_we = '0;
  logic [1:0][31:0] m_adr = '0, m_dat_w = '0;
  logic [1:0][3:0]  m_sel = '0;
  logic [1:0][31:0] m_dat_r;
  logic [1:0]       m_ack, m_err;

  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i = '0;

  always #5 clk_i = ~clk_i;

  dmem_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
    .m0_sel_i(m_sel[0]), .m0_dat_i(m_dat_w[0]), .m0_dat_o(m_dat_r[0]), .m0_ack_o(m_ack[0]),
    .m0_err_o(m_err[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
    .m1_sel_i(m_sel[1]), .m1_dat_i(m_dat_w[1]), .m1_dat_o(m_dat_r[1]), .m1_ack_o(m_ack[1]),
    .m1_err_o(m_err[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int stb_cnt = 0;
  int last_stb_cyc = -1;
  int last_resp_cyc [2] = '{-1, -1};
  int resp_cnt [2] = '{0, 0};
  logic [31:0] last_dat [2];
  bit [1:0] done = '0;

  logic [31:0] slv_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_prio = 1'b0;
  resp_t exp_q0 [$];
  resp_t exp_q1 [$];
  slv_t  slv_q [$];
  int    order_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] sel);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // Memory slave: acks in the strobe cycle, read data registered into the next cycle.
  assign s_ack_i = s_cyc_o & s_stb_o;
  initial begin : slave_model
    int unsigned sidx;
    for (int i = 0; i < int'(DEPTH); i++) slv_mem[i] = '0;
    forever begin
      @(posedge clk_i);
      if (s_cyc_o && s_stb_o) begin
        sidx = 32'(s_adr_o[27:2]);
        if (sidx < DEPTH) begin
          if (s_we_o) slv_mem[sidx] <= merge(slv_mem[sidx], s_dat_o, s_sel_o);
          else        s_dat_i <= slv_mem[sidx];
        end
      end
    end
  end

  initial forever begin
    @(posedge clk_i);
    cyc_cnt++;
  end

  // Reference model: one call per transfer, in the order the masters are expected to be served.
  task automatic model_one(input int m, input req_t r, input bit respond);
    int unsigned idx;
    resp_t e;
    slv_t  s;
    idx = (r.adr >> 2) & 32'h03FF_FFFF;
    e.is_err = (idx >= DEPTH);
    e.dat    = '0;
    if (!e.is_err) begin
      s.we = r.we; s.adr = r.adr; s.sel = r.sel; s.dat = r.dat;
      slv_q.push_back(s);
      if (r.we) ref_mem[idx] = merge(ref_mem[idx], r.dat, r.sel);
      else      e.dat = ref_mem[idx];
    end
    if (respond) begin
      order_q.push_back(m);
      if (m == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    ref_prio = (m == 0);
  endtask

  task automatic model_round(input req_t r0, input req_t r1);
    bit first;
    if (r0.en && r1.en) begin
      first = ref_prio;
      model_one(int'(first),  first ? r1 : r0, 1'b1);
      model_one(int'(!first), first ? r0 : r1, 1'b1);
    end else if (r0.en) model_one(0, r0, 1'b1);
    else if (r1.en)     model_one(1, r1, 1'b1);
  endtask

  // Monitor: pops expectations whenever the DUT terminates a transfer or strobes the slave.
  initial begin : monitor
    resp_t e;
    slv_t  s;
    forever begin
      @(negedge clk_i);
      for (int m = 0; m < 2; m++) begin
        if (m_ack[m] || m_err[m]) begin
          resp_cnt[m]++;
          last_resp_cyc[m] = cyc_cnt;
          last_dat[m] = m_dat_r[m];
          done[m] = 1'b1;
          if (order_q.size() == 0 || (m == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0)) begin
            total++; bad++;
            $display("FAIL m%0d_unexpected_resp: actual ack=%b err=%b required none", m, m_ack[m], m_err[m]);
          end else begin
            if (m == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("m%0d_grant_order", m), order_q.pop_front(), m);
            check($sformatf("m%0d_ack_err", m), {m_ack[m], m_err[m]}, e.is_err ? 2'b01 : 2'b10);
            check($sformatf("m%0d_rdata", m), m_dat_r[m], e.dat);
          end
        end else begin
          check($sformatf("m%0d_idle_dat", m), m_dat_r[m], '0);
        end
      end
      if (s_cyc_o && s_stb_o) begin
        stb_cnt++;
        last_stb_cyc = cyc_cnt;
        if (slv_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: actual adr=0x%08h required none", s_adr_o);
        end else begin
          s = slv_q.pop_front();
          check("slave_we", s_we_o, s.we);
          check("slave_adr", s_adr_o, s.adr);
          check("slave_sel", s_sel_o, s.sel);
          if (s.we) check("slave_wdat", s_dat_o, s.dat);
        end
      end
    end
  end

  task automatic drive_m(input int m, input req_t r);
    m_cyc[m] = r.en; m_stb[m] = r.en; m_we[m] = r.we;
    m_adr[m] = r.adr; m_sel[m] = r.sel; m_dat_w[m] = r.dat;
  endtask

  function automatic req_t mk(input bit en, input bit we, input logic [31:0] adr,
                              input logic [3:0] sel, input logic [31:0] dat);
    req_t r;
    r.en = en; r.we = we; r.adr = adr; r.sel = sel; r.dat = dat;
    return r;
  endfunction

  function automatic req_t rand_req(input bit in_range);
    req_t r;
    int unsigned idx;
    idx = $urandom_range(0, 15);
    if (!in_range && $urandom_range(0, 7) == 0) idx = DEPTH + $urandom_range(0, 5000);
    r.en  = 1'b1;
    r.we  = 1'($urandom_range(0, 1));
    r.adr = {4'($urandom_range(0, 15)), 26'(idx), 2'($urandom_range(0, 3))};
    r.sel = 4'($urandom_range(1, 15));
    r.dat = $urandom;
    return r;
  endfunction

  // Called just after a clock edge while the DUT is idle; returns just after the edge that opens the next IDLE.
  task automatic run_round(input req_t r0, input req_t r1, output int issue);
    bit fin;
    done = '0;
    drive_m(0, r0);
    drive_m(1, r1);
    issue = cyc_cnt;
    model_round(r0, r1);
    fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(posedge clk_i); #1;
      for (int m = 0; m < 2; m++) if (done[m]) drive_m(m, '0);
      fin = (!r0.en || done[0]) && (!r1.en || done[1]);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL round_timeout: actual done=%b required all requesters terminated", done);
      drive_m(0, '0);
      drive_m(1, '0);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int issue;
    int a0 [3];
    int a1 [3];
    int stb_before;
    int resp_before;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    // Reset state
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ctrl_outputs", {m_ack, m_err, s_cyc_o, s_stb_o, s_we_o, s_sel_o}, '0);
    check("reset_data_outputs", m_dat_r[0] | m_dat_r[1] | s_adr_o | s_dat_o, '0);
    @(posedge clk_i); #1 reset_n = 1'b1;
    @(posedge clk_i); #1;

    // Both masters requesting back to back from reset: grants alternate, each served every 6 cycles
    for (int r = 0; r < 3; r++) begin
      run_round(rand_req(1'b1), rand_req(1'b1), issue);
      a0[r] = last_resp_cyc[0];
      a1[r] = last_resp_cyc[1];
    end
    check("fair_m0_first", a1[0] - a0[0], 3);
    check("fair_m0_period_a", a0[1] - a0[0], 6);
    check("fair_m0_period_b", a0[2] - a0[1], 6);
    check("fair_m1_period", a1[2] - a1[1], 6);

    // Write then read back 0x10 with latency checks
    run_round(mk(1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF), '0, issue);
    run_round(mk(1, 0, 32'h10, 4'hF, 32'h0), '0, issue);
    check("read_strobe_latency", last_stb_cyc - issue, 1);
    check("read_ack_latency", last_resp_cyc[0] - issue, 2);
    check("read_data_deadbeef", last_dat[0], 32'hDEAD_BEEF);

    // Byte-lane write from m1 over an existing word
    run_round(mk(1, 1, 32'h20, 4'hF, 32'h1122_3344), '0, issue);
    run_round('0, mk(1, 1, 32'h20, 4'b0010, 32'h0000_AB00), issue);
    run_round(mk(1, 0, 32'h20, 4'hF, 32'h0), '0, issue);
    check("byte_lane_merge", last_dat[0], 32'h1122_AB44);

    // First out-of-range word: err one cycle after the request, slave never strobed
    stb_before = stb_cnt;
    run_round(mk(1, 0, DEPTH * 4, 4'hF, 32'h0), '0, issue);
    check("oor_err_latency", last_resp_cyc[0] - issue, 1);
    check("oor_no_strobe", stb_cnt - stb_before, 0);

    // m0 abandons a write during ISSUE: write still lands, no ack, priority still passes to m1
    resp_before = resp_cnt[0];
    drive_m(0, mk(1, 1, 32'h40, 4'hF, 32'hCAFE_F00D));
    model_one(0, mk(1, 1, 32'h40, 4'hF, 32'hCAFE_F00D), 1'b0);
    @(posedge clk_i); #1;
    drive_m(0, '0);
    repeat (2) begin @(posedge clk_i); #1; end
    check("drop_no_ack", resp_cnt[0] - resp_before, 0);
    run_round(mk(1, 0, 32'h40, 4'hF, 32'h0), mk(1, 0, 32'h44, 4'hF, 32'h0), issue);
    check("drop_then_m1_first", 32'(last_resp_cyc[1] < last_resp_cyc[0]), 1);
    check("drop_write_landed", last_dat[0], 32'hCAFE_F00D);

    // Reset during RESP: outputs clear immediately, arbitration restarts with m0 preferred
    resp_before = resp_cnt[0];
    drive_m(0, mk(1, 0, 32'h10, 4'hF, 32'h0));
    model_one(0, mk(1, 0, 32'h10, 4'hF, 32'h0), 1'b0);
    repeat (2) begin @(posedge clk_i); #1; end
    reset_n = 1'b0;
    drive_m(0, '0);
    #1;
    check("rst_mid_ctrl", {m_ack, m_err, s_cyc_o, s_stb_o, s_we_o, s_sel_o}, '0);
    check("rst_mid_data", m_dat_r[0] | m_dat_r[1] | s_adr_o | s_dat_o, '0);
    @(posedge clk_i); #1;
    check("rst_mid_no_ack", resp_cnt[0] - resp_before, 0);
    reset_n = 1'b1;
    ref_prio = 1'b0;
    @(posedge clk_i); #1;
    run_round(rand_req(1'b1), rand_req(1'b1), issue);
    check("rst_then_m0_first", 32'(last_resp_cyc[0] < last_resp_cyc[1]), 1);

    // Random traffic
    for (int r = 0; r < 200; r++) begin
      req_t r0, r1;
      int pick;
      pick = $urandom_range(0, 2);
      r0 = (pick != 1) ? rand_req(1'b0) : req_t'('0);
      r1 = (pick != 0) ? rand_req(1'b0) : req_t'('0);
      run_round(r0, r1, issue);
    end

    repeat (3) @(posedge clk_i);
    check("leftover_m0_expect", exp_q0.size(), 0);
    check("leftover_m1_expect", exp_q1.size(), 0);
    check("leftover_slave_expect", slv_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
